// File: rtl/axil_pkg.sv
// axil_pkg: AXI4-Lite response codes and write-side FSM states
// shared by the read and write adapters.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT_B = 3'd2,
    RESP   = 3'd3,
    DRAIN  = 3'd4
  } wr_state_t;

endpackage

// File: rtl/axil_wdog.sv
// axil_wdog: cycle counter, cleared by clr, advanced by en.
// expire is high while en is set and the count sits at LIMIT-1.
module axil_wdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/axil_write_adapter.sv
// axil_write_adapter: replays one upstream AXI-Lite write (s_axi_*)
// on the fabric port (m_axi_*), returns BRESP, SLVERR on watchdog.
// Ports: clk, rst_n (async, active low); s_axi_aw*/w*/b* slave side;
// m_axi_aw*/w*/b* master side; timeout_o pulses when watchdog fires.
module axil_write_adapter
  import axil_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [2:0]          s_axi_awprot,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic                timeout_o
);

  wr_state_t state;
  logic      aw_got;
  logic      w_got;
  logic      drain_pend;

  logic aw_hs;
  logic w_hs;
  logic aw_done;
  logic w_done;
  logic maw_ok;
  logic mw_ok;
  logic mb_hs;
  logic wd_clr;
  logic wd_en;
  logic wd_expire;
  logic fire;
  logic unused_prot;

  assign unused_prot = ^s_axi_awprot;
  assign m_axi_awprot = 3'b000;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign aw_done = aw_got || aw_hs;
  assign w_done  = w_got || w_hs;

  // An M channel counts as done once its valid is low or
  // its handshake completes on this edge.
  assign maw_ok = !m_axi_awvalid || m_axi_awready;
  assign mw_ok  = !m_axi_wvalid || m_axi_wready;
  assign mb_hs  = m_axi_bvalid && m_axi_bready;

  assign wd_clr = (state == IDLE) && aw_done && w_done;
  assign wd_en  = (state == ISSUE) || (state == WAIT_B);

  generate
    if (TIMEOUT_CYC > 0) begin : g_wdog
      axil_wdog #(
        .LIMIT (TIMEOUT_CYC)
      ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
      );
    end else begin : g_no_wdog
      assign wd_expire = 1'b0;
    end
  endgenerate

  // A real response arriving on the expiry cycle wins.
  assign fire      = wd_expire && !mb_hs;
  assign timeout_o = fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      aw_got        <= 1'b0;
      w_got         <= 1'b0;
      drain_pend    <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bvalid  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      if (m_axi_awvalid && m_axi_awready) begin
        m_axi_awvalid <= 1'b0;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        m_axi_wvalid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (aw_hs) begin
            m_axi_awaddr <= s_axi_awaddr;
            aw_got       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wdata <= s_axi_wdata;
            m_axi_wstrb <= s_axi_wstrb;
            w_got       <= 1'b1;
          end
          if (aw_done && w_done) begin
            aw_got        <= 1'b0;
            w_got         <= 1'b0;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= ISSUE;
          end else begin
            s_axi_awready <= s_axi_awvalid && !aw_done
                             && !s_axi_awready;
            s_axi_wready  <= s_axi_wvalid && !w_done
                             && !s_axi_wready;
          end
        end
        ISSUE: begin
          if (fire) begin
            s_axi_bresp  <= RESP_SLVERR;
            s_axi_bvalid <= 1'b1;
            drain_pend   <= 1'b1;
            state        <= RESP;
          end else if (maw_ok && mw_ok) begin
            m_axi_bready <= 1'b1;
            state        <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (mb_hs) begin
            s_axi_bresp  <= m_axi_bresp;
            s_axi_bvalid <= 1'b1;
            m_axi_bready <= 1'b0;
            state        <= RESP;
          end else if (fire) begin
            s_axi_bresp  <= RESP_SLVERR;
            s_axi_bvalid <= 1'b1;
            m_axi_bready <= 1'b0;
            drain_pend   <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= drain_pend ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          // Finish AW/W first, then take and drop the late B.
          if (mb_hs) begin
            m_axi_bready <= 1'b0;
            drain_pend   <= 1'b0;
            state        <= IDLE;
          end else if (maw_ok && mw_ok) begin
            m_axi_bready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_write_adapter.sv
// tb_axil_write_adapter: directed scoreboard bench for the
// AXI-Lite write adapter (TIMEOUT_CYC = 16).
module tb_axil_write_adapter;
  import axil_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] s_axi_awaddr = '0;
  logic [2:0]    s_axi_awprot = '0;
  logic          s_axi_awvalid = 1'b0;
  logic          s_axi_awready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [SW-1:0] s_axi_wstrb = '0;
  logic          s_axi_wvalid = 1'b0;
  logic          s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid;
  logic          s_axi_bready = 1'b0;
  logic [AW-1:0] m_axi_awaddr;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b0;
  logic [1:0]    m_axi_bresp = '0;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;
  logic          timeout_o;

  always #5 clk = ~clk;

  axil_write_adapter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .timeout_o     (timeout_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [AW-1:0]    exp_aw[$];
  logic [DW+SW-1:0] exp_w[$];
  logic [1:0]       exp_b[$];

  int n_awr = 0;
  int n_wr = 0;
  int n_mawv = 0;
  int n_mwv = 0;
  int n_mv = 0;
  int n_to = 0;
  int n_b = 0;
  int n_sbv = 0;
  int bv_cyc = -1;
  int to_cyc = -1;
  bit b_pulse = 1'b0;

  logic          p_mawv = 1'b0;
  logic          p_mawr = 1'b0;
  logic [AW-1:0] p_awaddr = '0;
  logic          p_mwv = 1'b0;
  logic          p_mwr = 1'b0;
  logic [DW+SW-1:0] p_w = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample just after the negedge, then advance one cycle.
  task automatic tick();
    logic aw_h;
    logic w_h;
    logic mb_h;
    #1;
    aw_h = s_axi_awvalid && s_axi_awready;
    w_h  = s_axi_wvalid && s_axi_wready;
    mb_h = m_axi_bvalid && m_axi_bready;
    if (s_axi_awready) n_awr++;
    if (s_axi_wready) n_wr++;
    if (m_axi_awvalid) n_mawv++;
    if (m_axi_wvalid) n_mwv++;
    if (m_axi_awvalid || m_axi_wvalid) n_mv++;
    if (s_axi_bvalid) n_sbv++;
    if (timeout_o) begin
      n_to++;
      if (to_cyc < 0) to_cyc = cyc;
    end
    if (s_axi_bvalid && bv_cyc < 0) bv_cyc = cyc;
    if (m_axi_awvalid && p_mawv && !p_mawr)
      chk("m_aw_stable", m_axi_awaddr, p_awaddr);
    if (m_axi_wvalid && p_mwv && !p_mwr)
      chk("m_w_stable", {m_axi_wdata, m_axi_wstrb}, p_w);
    if (m_axi_awvalid && m_axi_awready) begin
      chk("m_aw_expected", exp_aw.size() > 0, 1);
      chk("m_awprot", m_axi_awprot, 3'b000);
      if (exp_aw.size() > 0)
        chk("m_awaddr", m_axi_awaddr, exp_aw.pop_front());
    end
    if (m_axi_wvalid && m_axi_wready) begin
      chk("m_w_expected", exp_w.size() > 0, 1);
      if (exp_w.size() > 0)
        chk("m_wdata_strb", {m_axi_wdata, m_axi_wstrb},
            exp_w.pop_front());
    end
    if (s_axi_bvalid && s_axi_bready) begin
      n_b++;
      chk("s_b_expected", exp_b.size() > 0, 1);
      if (exp_b.size() > 0)
        chk("s_bresp", s_axi_bresp, exp_b.pop_front());
    end
    p_mawv = m_axi_awvalid;
    p_mawr = m_axi_awready;
    p_awaddr = m_axi_awaddr;
    p_mwv = m_axi_wvalid;
    p_mwr = m_axi_wready;
    p_w = {m_axi_wdata, m_axi_wstrb};
    cyc++;
    @(negedge clk);
    if (aw_h) s_axi_awvalid = 1'b0;
    if (w_h) s_axi_wvalid = 1'b0;
    if (mb_h && b_pulse) m_axi_bvalid = 1'b0;
  endtask

  task automatic run_until_b(input int target, input int budget,
                             input string tag);
    int n = 0;
    while (n_b < target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, n_b >= target, 1);
  endtask

  task automatic send_aw(input logic [AW-1:0] a);
    exp_aw.push_back(a);
    s_axi_awaddr = a;
    s_axi_awprot = 3'b101;
    s_axi_awvalid = 1'b1;
  endtask

  task automatic send_w(input logic [DW-1:0] d,
                        input logic [SW-1:0] s);
    exp_w.push_back({d, s});
    s_axi_wdata = d;
    s_axi_wstrb = s;
    s_axi_wvalid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t0;
    int b0;
    int b1;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {s_axi_awready, s_axi_wready, s_axi_bvalid,
        s_axi_bresp, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
        timeout_o}, 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    chk("rst_wdata_strb", {m_axi_wdata, m_axi_wstrb}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: AW+W same cycle, 4-cycle latency to s_bvalid
    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    m_axi_bvalid = 1'b1;
    m_axi_bresp = RESP_OKAY;
    s_axi_bready = 1'b1;
    send_aw(32'h10);
    send_w(32'hDEADBEEF, 4'hF);
    exp_b.push_back(RESP_OKAY);
    bv_cyc = -1;
    t0 = cyc;
    run_until_b(n_b + 1, 20, "t1_done");
    chk("t1_latency", bv_cyc - t0, 4);
    repeat (2) tick();

    // 2: W three cycles ahead of AW
    b0 = n_wr;
    b1 = n_mv;
    send_w(32'h12345678, 4'h5);
    exp_b.push_back(RESP_OKAY);
    repeat (3) tick();
    chk("t2_w_taken", s_axi_wvalid, 0);
    chk("t2_no_m_early", n_mv - b1, 0);
    send_aw(32'h24);
    run_until_b(n_b + 1, 20, "t2_done");
    chk("t2_wready_pulses", n_wr - b0, 1);
    repeat (2) tick();

    // 3: m_awready held off for 5 cycles
    m_axi_awready = 1'b0;
    send_aw(32'h0000_1000);
    send_w(32'hCAFE0001, 4'h3);
    exp_b.push_back(RESP_OKAY);
    n = 0;
    while (!m_axi_awvalid && n < 10) begin
      tick();
      n++;
    end
    chk("t3_issue", m_axi_awvalid, 1);
    b0 = n_mawv;
    b1 = n_mwv;
    repeat (5) tick();
    m_axi_awready = 1'b1;
    run_until_b(n_b + 1, 20, "t3_done");
    chk("t3_mawvalid_cycles", n_mawv - b0, 6);
    chk("t3_mwvalid_cycles", n_mwv - b1, 1);
    repeat (2) tick();

    // 4: SLVERR held while s_bready low, no AW taken
    m_axi_bresp = RESP_SLVERR;
    s_axi_bready = 1'b0;
    send_aw(32'h40);
    send_w(32'h0BADF00D, 4'hC);
    exp_b.push_back(RESP_SLVERR);
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      tick();
      n++;
    end
    send_aw(32'h80);
    b0 = n_awr;
    b1 = n_sbv;
    repeat (4) tick();
    chk("t4_bvalid_held", n_sbv - b1, 4);
    chk("t4_bresp", s_axi_bresp, RESP_SLVERR);
    chk("t4_no_awready", n_awr - b0, 0);
    s_axi_bready = 1'b1;
    m_axi_bresp = RESP_OKAY;
    send_w(32'h00000080, 4'h1);
    exp_b.push_back(RESP_OKAY);
    run_until_b(n_b + 2, 30, "t4_done");
    repeat (2) tick();

    // 5: watchdog, then late B swallowed in DRAIN
    m_axi_bvalid = 1'b0;
    b_pulse = 1'b1;
    send_aw(32'h5C);
    send_w(32'h55AA55AA, 4'hF);
    exp_b.push_back(RESP_SLVERR);
    n = 0;
    while (!m_axi_awvalid && n < 10) begin
      tick();
      n++;
    end
    t0 = cyc;
    to_cyc = -1;
    b0 = n_to;
    run_until_b(n_b + 1, 40, "t5_resp");
    chk("t5_timeout_cycle", to_cyc - t0, 15);
    chk("t5_timeout_pulses", n_to - b0, 1);
    repeat (2) tick();
    chk("t5_drain_bready", m_axi_bready, 1);
    b1 = n_b;
    m_axi_bvalid = 1'b1;
    m_axi_bresp = 2'b01;
    repeat (3) tick();
    chk("t5_late_b_taken", m_axi_bvalid, 0);
    chk("t5_bready_low", m_axi_bready, 0);
    chk("t5_no_extra_b", n_b - b1, 0);
    m_axi_bresp = RESP_OKAY;
    m_axi_bvalid = 1'b1;
    send_aw(32'h60);
    send_w(32'h0000_0060, 4'hF);
    exp_b.push_back(RESP_OKAY);
    run_until_b(n_b + 1, 20, "t5_next_ok");
    repeat (2) tick();

    // 6: reset while in WAIT_B
    m_axi_bvalid = 1'b0;
    send_aw(32'h70);
    send_w(32'h7777_7777, 4'hF);
    n = 0;
    while (!m_axi_bready && n < 10) begin
      tick();
      n++;
    end
    chk("t6_wait_b", m_axi_bready, 1);
    #2;
    rst_n = 1'b0;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    #1;
    chk("t6_rst_ctrl", {s_axi_awready, s_axi_wready, s_axi_bvalid,
        s_axi_bresp, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
        timeout_o}, 0);
    chk("t6_rst_data", {m_axi_awaddr, m_axi_wdata, m_axi_wstrb}, 0);
    chk("t6_rst_state", dut.state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    p_mawv = 1'b0;
    p_mwv = 1'b0;
    @(negedge clk);
    m_axi_bvalid = 1'b1;
    send_aw(32'h74);
    send_w(32'hA5A5_0074, 4'h9);
    exp_b.push_back(RESP_OKAY);
    run_until_b(n_b + 1, 20, "t6_after_rst");
    repeat (2) tick();
    chk("sb_empty", exp_aw.size() + exp_w.size() + exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
